// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and defaults for the pipelined CLA adder
package cla_pkg;
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } cla_op_e;

    localparam int CLA_SEG_W = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } cla_flags_t;
endpackage

// File: rtl/cla_seg.sv
// rtl/cla_seg.sv - combinational SEG_W-bit carry-lookahead segment
module cla_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             p,
    output logic             g
);
    logic [SEG_W-1:0] bit_p;
    logic [SEG_W-1:0] bit_g;
    logic [SEG_W:0]   carry;
    logic             prop;
    logic             gen;

    assign bit_p = a ^ b;
    assign bit_g = a & b;

    // Each carry is a flat sum of products over the bits below it rather than a ripple.
    always_comb begin
        carry    = '0;
        carry[0] = cin;
        prop     = 1'b1;
        gen      = 1'b0;
        for (int i = 0; i < SEG_W; i++) begin
            prop = 1'b1;
            gen  = 1'b0;
            for (int j = i; j >= 0; j--) begin
                gen  = gen | (bit_g[j] & prop);
                prop = prop & bit_p[j];
            end
            carry[i+1] = gen | (prop & cin);
        end
    end

    assign sum  = bit_p ^ carry[SEG_W-1:0];
    assign cout = carry[SEG_W];
    assign p    = &bit_p;
    assign g    = gen;
endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined segmented CLA adder/subtractor; CLA_PIPE_SAT_EN enables signed saturation
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = CLA_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NUM_SEG = WIDTH / SEG_W;
    localparam int LAST    = NUM_SEG - 1;

    cla_op_e          op;
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic             v_q     [NUM_SEG];
    logic             c_q     [NUM_SEG];
    logic [WIDTH-1:0] a_q     [NUM_SEG];
    logic [WIDTH-1:0] b_q     [NUM_SEG];
    logic [WIDTH-1:0] s_q     [NUM_SEG];
    cla_flags_t       flags_q;

    logic             v_src   [NUM_SEG];
    logic             c_src   [NUM_SEG];
    logic [WIDTH-1:0] a_src   [NUM_SEG];
    logic [WIDTH-1:0] b_src   [NUM_SEG];
    logic [WIDTH-1:0] s_src   [NUM_SEG];
    logic [SEG_W-1:0] seg_sum [NUM_SEG];
    logic             seg_co  [NUM_SEG];
    logic             seg_p   [NUM_SEG];
    logic             seg_g   [NUM_SEG];
    logic [WIDTH-1:0] s_nxt   [NUM_SEG];

    logic [WIDTH-1:0] raw_sum;
    logic [WIDTH-1:0] res_sum;
    logic             fin_cout;
    logic             msb_cin;
    logic             raw_ovf;

    assign op       = cla_op_e'(in_op);
    assign b_eff    = (op == OP_SUB) ? ~in_b : in_b;
    assign cin_eff  = (op == OP_SUB) ? 1'b1 : in_cin;
    assign advance  = ~v_q[LAST] | out_ready;
    assign in_ready = advance;

    // Operands shift down one segment per stage so each stage always consumes the low SEG_W bits.
    for (genvar k = 0; k < NUM_SEG; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_src[k] = in_valid;
            assign c_src[k] = cin_eff;
            assign a_src[k] = in_a;
            assign b_src[k] = b_eff;
            assign s_src[k] = '0;
        end else begin : g_tail
            assign v_src[k] = v_q[k-1];
            assign c_src[k] = c_q[k-1];
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
        end

        cla_seg #(.SEG_W(SEG_W)) u_seg (
            .a    (a_src[k][SEG_W-1:0]),
            .b    (b_src[k][SEG_W-1:0]),
            .cin  (c_src[k]),
            .sum  (seg_sum[k]),
            .cout (seg_co[k]),
            .p    (seg_p[k]),
            .g    (seg_g[k])
        );

        // New segment enters at the top; earlier ones slide down and land in place at the last stage.
        assign s_nxt[k] = (s_src[k] >> SEG_W) | (WIDTH'(seg_sum[k]) << (WIDTH - SEG_W));
    end

    always_comb begin
        raw_sum  = s_nxt[LAST];
        fin_cout = seg_g[LAST] | (seg_p[LAST] & c_src[LAST]);
        msb_cin  = raw_sum[WIDTH-1] ^ a_src[LAST][SEG_W-1] ^ b_src[LAST][SEG_W-1];
        raw_ovf  = fin_cout ^ msb_cin;
        res_sum  = raw_sum;
`ifdef CLA_PIPE_SAT_EN
        if (raw_ovf) begin
            res_sum = a_src[LAST][SEG_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            flags_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                v_q[k] <= v_src[k];
                c_q[k] <= seg_co[k];
                a_q[k] <= a_src[k] >> SEG_W;
                b_q[k] <= b_src[k] >> SEG_W;
                s_q[k] <= (k == LAST) ? res_sum : s_nxt[k];
            end
            flags_q.cout <= fin_cout;
            flags_q.ovf  <= raw_ovf;
            flags_q.zero <= ~|res_sum;
        end
    end

    assign out_valid = v_q[LAST];
    assign out_sum   = s_q[LAST];
    assign out_cout  = flags_q.cout;
    assign out_ovf   = flags_q.ovf;
    assign out_zero  = flags_q.zero;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - randomized self-checking bench for cla_pipe_adder
module tb_cla_pipe_adder;
    localparam int W   = 16;
    localparam int SEG = 4;
    localparam int LAT = W / SEG;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .SEG_W(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    res_t exp_q[$];
    res_t held_r;
    res_t last_r;
    logic held     = 1'b0;
    logic accepted = 1'b0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_ret    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Signed/unsigned integer arithmetic on the operands, independent of any segment structure.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic op);
        res_t   r;
        int     sa, sb, sr;
        int     smax, smin;
        longint ua, ub;
        sa   = int'($signed(a));
        sb   = int'($signed(b));
        ua   = longint'(a);
        ub   = longint'(b);
        smax = (1 <<< (W - 1)) - 1;
        smin = -(1 <<< (W - 1));
        if (op) begin
            sr     = sa - sb;
            r.cout = (ua >= ub);
            r.sum  = W'(ua - ub);
        end else begin
            sr     = sa + sb + int'(cin);
            r.cout = ((ua + ub + longint'(cin)) >= (longint'(1) <<< W));
            r.sum  = W'(ua + ub + longint'(cin));
        end
        r.ovf = (sr > smax) || (sr < smin);
`ifdef CLA_PIPE_SAT_EN
        if (sr > smax) r.sum = W'(smax);
        else if (sr < smin) r.sum = W'(smin);
`endif
        r.zero = (r.sum == '0);
        return r;
    endfunction

    task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic op, input logic rdy);
        res_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_op     = op;
        out_ready = rdy;
        #1;
        if (held) begin
            check_eq("stall_valid", out_valid, 1'b1);
            check_eq("stall_sum", out_sum, held_r.sum);
            check_eq("stall_flags", {out_cout, out_ovf, out_zero},
                     {held_r.cout, held_r.ovf, held_r.zero});
        end
        held = out_valid && !rdy;
        if (held) held_r = '{out_sum, out_cout, out_ovf, out_zero};
        if (out_valid && rdy) begin
            n_ret++;
            last_r = '{out_sum, out_cout, out_ovf, out_zero};
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sum", out_sum, e.sum);
                check_eq("cout", out_cout, e.cout);
                check_eq("ovf", out_ovf, e.ovf);
                check_eq("zero", out_zero, e.zero);
            end
        end
        accepted = v && in_ready;
        if (accepted) exp_q.push_back(model(a, b, cin, op));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            n++;
        end
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] corner [4];
        logic [W-1:0] ra, rb;
        int lat, cyc, i;
        corner = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_op = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_sum", out_sum, 16'h0000);
        check_eq("rst_flags", {out_cout, out_ovf, out_zero}, 3'b000);
        check_eq("rst_in_ready", in_ready, 1'b1);

        // 0x00FF + 0x0001 with latency measurement
        cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        check_eq("t1_accepted", accepted, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            lat++;
        end
        check_eq("latency", lat, LAT);
        drain();
        check_eq("t1_sum", last_r.sum, 16'h0100);
        check_eq("t1_flags", {last_r.cout, last_r.ovf, last_r.zero}, 3'b000);

        cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1);
        drain();
        check_eq("t2_sum", last_r.sum, 16'h0000);
        check_eq("t2_flags", {last_r.cout, last_r.ovf, last_r.zero}, 3'b101);

        cycle(1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
        drain();
`ifdef CLA_PIPE_SAT_EN
        check_eq("t3_sum", last_r.sum, 16'h7FFF);
`else
        check_eq("t3_sum", last_r.sum, 16'h8000);
`endif
        check_eq("t3_ovf", last_r.ovf, 1'b1);

        // in_cin must be ignored on SUB
        cycle(1'b1, 16'h1234, 16'h1234, 1'b1, 1'b1, 1'b1);
        drain();
        check_eq("t6_sum", last_r.sum, 16'h0000);
        check_eq("t6_flags", {last_r.cout, last_r.ovf, last_r.zero}, 3'b101);

        // back-to-back with out_ready 1,0,0 repeating
        n_ret = 0; i = 0; cyc = 0;
        while (i < 8 && cyc < 200) begin
            cycle(1'b1, W'(i), W'(i * 3), 1'b0, 1'b0, (cyc % 3) == 0);
            if (accepted) i++;
            cyc++;
        end
        while (exp_q.size() != 0 && cyc < 400) begin
            cycle(1'b0, '0, '0, 1'b0, 1'b0, (cyc % 3) == 0);
            cyc++;
        end
        check_eq("b2b_count", n_ret, 8);
        drain();

        // reset with three beats in flight
        repeat (3) cycle(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        held = 1'b0;
        check_eq("rst_mid_valid", out_valid, 1'b0);
        check_eq("rst_mid_ready", in_ready, 1'b1);
        n_ret = 0;
        repeat (10) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("rst_mid_none", n_ret, 0);

        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            cycle($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2) != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
